// File: rtl/ball_avionics_pkg.sv
// Shared definitions for the timestamp telemetry path: frame layout,
// framer state encoding and the frame byte selector.
package ball_avionics_pkg;

  localparam int         FRAME_LEN          = 6;
  localparam logic [7:0] DEFAULT_SYNC_BYTE  = 8'hA5;
  localparam int         DEFAULT_STABLE_CNT = 2;

  typedef logic [2:0] byte_idx_t;

  localparam byte_idx_t IDX_SYNC   = 3'd0;
  localparam byte_idx_t IDX_EVT    = 3'd1;
  localparam byte_idx_t IDX_TS_HI  = 3'd2;
  localparam byte_idx_t IDX_TS_MID = 3'd3;
  localparam byte_idx_t IDX_TS_LO  = 3'd4;
  localparam byte_idx_t IDX_CSUM   = byte_idx_t'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Byte at position idx of the frame built from a latched snapshot.
  function automatic logic [7:0] frame_byte(
    input logic [7:0]  sync_byte,
    input logic [7:0]  evt,
    input logic [23:0] ts,
    input byte_idx_t   idx
  );
    logic [7:0] w_byte;
    w_byte = 8'h00;
    case (idx)
      IDX_SYNC:   w_byte = sync_byte;
      IDX_EVT:    w_byte = evt;
      IDX_TS_HI:  w_byte = ts[23:16];
      IDX_TS_MID: w_byte = ts[15:8];
      IDX_TS_LO:  w_byte = ts[7:0];
      IDX_CSUM:   w_byte = evt ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
      default:    w_byte = 8'h00;
    endcase
    return w_byte;
  endfunction

endpackage

// File: rtl/ts_sync.sv
// Brings the slow, asynchronous timestamp count into the CLK domain and
// flags when the synchronised word has been steady long enough to trust.
module ts_sync #(
  parameter int STABLE_CNT = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] TIMESTAMP,
  output logic [23:0] TS_OUT,
  output logic        TS_VALID
);

  localparam int             CW      = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT);

  logic [23:0]   r_ts_s1;
  logic [23:0]   r_ts_s2;
  logic [CW-1:0] r_cnt;

  // NOTE: non-blocking assignments give every flop its pre-edge value on the
  // right-hand side, so r_ts_s2 takes the old r_ts_s1 and the compare below
  // sees both stages as they stood before this edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ts_s1 <= '0;
      r_ts_s2 <= '0;
      r_cnt   <= '0;
    end else begin
      r_ts_s1 <= TIMESTAMP;
      r_ts_s2 <= r_ts_s1;
      // A multi-bit count can be caught mid-transition; only a run of equal
      // samples proves the word settled.
      if (r_ts_s1 == r_ts_s2) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign TS_OUT   = r_ts_s2;
  assign TS_VALID = (r_cnt == CNT_MAX);

endmodule

// File: rtl/timestamp_framer.sv
// Snapshots the synchronised 10 Hz timestamp on each CAPTURE request and
// streams it as a 6-byte checksummed frame over a valid/ready byte link.
module timestamp_framer
  import ball_avionics_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int         STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] TIMESTAMP,
  input  logic        CAPTURE,
  input  logic [7:0]  EVENT_ID,
  input  logic        TX_READY,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  output logic        BUSY,
  output logic        OVERRUN,
  input  logic        OVERRUN_CLR
);

  logic [23:0] w_ts;
  logic        w_ts_valid;
  logic        w_xfer;
  logic        w_drop;

  state_t      r_state;
  logic        r_pending;
  logic [7:0]  r_req_evt;
  logic        r_overrun;
  logic [23:0] r_ts_snap;
  logic [7:0]  r_evt_snap;
  byte_idx_t   r_idx;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  ts_sync #(
    .STABLE_CNT (STABLE_CNT)
  ) u_ts_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .TIMESTAMP (TIMESTAMP),
    .TS_OUT    (w_ts),
    .TS_VALID  (w_ts_valid)
  );

  assign w_xfer = r_tx_valid & TX_READY;
  assign w_drop = CAPTURE & r_pending;

  // Request register: one pending slot; a request arriving while it is
  // occupied is discarded and recorded in the sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending <= 1'b0;
      r_req_evt <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      if (w_drop)           r_overrun <= 1'b1;
      else if (OVERRUN_CLR) r_overrun <= 1'b0;

      if (CAPTURE && !r_pending) begin
        r_pending <= 1'b1;
        r_req_evt <= EVENT_ID;
      end else if (r_state == ST_SNAP && w_ts_valid) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Framer FSM with registered stream outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_ts_snap  <= '0;
      r_evt_snap <= 8'h00;
      r_idx      <= IDX_SYNC;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending) r_state <= ST_SNAP;
        end

        ST_SNAP: begin
          if (w_ts_valid) begin
            r_ts_snap  <= w_ts;
            r_evt_snap <= r_req_evt;
            r_idx      <= IDX_SYNC;
            r_tx_data  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_xfer) begin
            if (r_idx == IDX_CSUM) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_idx      <= IDX_SYNC;
              // A request landing on this same edge is picked up from IDLE
              // on the following cycle.
              r_state    <= r_pending ? ST_SNAP : ST_IDLE;
            end else begin
              r_idx     <= r_idx + byte_idx_t'(1);
              r_tx_data <= frame_byte(SYNC_BYTE, r_evt_snap, r_ts_snap,
                                      r_idx + byte_idx_t'(1));
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign TX_DATA  = r_tx_data;
  assign TX_VALID = r_tx_valid;
  assign BUSY     = (r_state != ST_IDLE) | r_pending;
  assign OVERRUN  = r_overrun;

endmodule
